// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the fetch-stage PC / redirect logic.
package pc_redirect_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2,
      TRAP     = 2'd3
   } pc_state_t;

   // Br_Ctrl encodings used by the upstream compare unit
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Combinational redirect target (PC- or rs1-relative) and alignment check.
module pc_target_adder (
   input  logic [31:0] pc_e,
   input  logic [31:0] imm_e,
   input  logic [31:0] rs1_e,
   input  logic        jalr_e,
   output logic [31:0] target_c,
   output logic        misaligned_c
);
   import pc_redirect_pkg::*;

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;

   assign base = jalr_e ? rs1_e : pc_e;
   assign sum  = base + imm_e;

   // JALR discards bit 0 of the computed address
   assign target_c     = jalr_e ? (sum & ~XLEN'(1)) : sum;
   assign misaligned_c = ~is_word_aligned(target_c);

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register, next-PC selection, pipeline flushes and misaligned-target trap.
// Optional PC_PERF_CNT_EN adds branch_cnt / taken_cnt performance counters.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        fetch_ready,
   output logic        fetch_valid,
   output logic [31:0] pc_f,
   input  logic [31:0] pc_e,
   input  logic [31:0] imm_e,
   input  logic [31:0] rs1_e,
   input  logic        branch_e,
   input  logic        jump_e,
   input  logic        jalr_e,
   input  logic        br_out,
   output logic        flush_d,
   output logic        flush_e,
   output logic        misalign_trap,
   output logic [31:0] trap_tval,
   input  logic        trap_ack
`ifdef PC_PERF_CNT_EN
   ,
   output logic [31:0] branch_cnt,
   output logic [31:0] taken_cnt
`endif
);
   import pc_redirect_pkg::*;

   pc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] tval_d;
   logic            trap_d;
   logic [XLEN-1:0] target_c;
   logic            misaligned_c;
   logic            taken_c;
   logic            advance_c;

   pc_target_adder u_target (
      .pc_e         (pc_e),
      .imm_e        (imm_e),
      .rs1_e        (rs1_e),
      .jalr_e       (jalr_e),
      .target_c     (target_c),
      .misaligned_c (misaligned_c)
   );

   assign advance_c = fetch_ready & ~stall;

   // State register and all sequential PC/trap state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_f          <= RESET_VECTOR;
         misalign_trap <= 1'b0;
         trap_tval     <= '0;
      end else begin
         state_q       <= state_d;
         pc_f          <= pc_d;
         misalign_trap <= trap_d;
         trap_tval     <= tval_d;
      end
   end

   // Next-state, next-PC and flush/valid outputs
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_f;
      trap_d      = misalign_trap;
      tval_d      = trap_tval;
      taken_c     = 1'b0;
      fetch_valid = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            fetch_valid = 1'b1;
            taken_c     = jump_e | (branch_e & br_out);
            // A taken redirect wins over stall and a pending, unaccepted fetch
            if (taken_c) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
               if (misaligned_c) begin
                  trap_d  = 1'b1;
                  tval_d  = target_c;
                  state_d = TRAP;
               end else begin
                  pc_d    = target_c;
                  state_d = REDIRECT;
               end
            end else if (advance_c) begin
               pc_d = pc_f + PC_STEP;
            end
         end
         REDIRECT: begin
            // EX holds a flushed bubble here, so its controls are not looked at
            fetch_valid = 1'b1;
            if (advance_c) begin
               pc_d = pc_f + PC_STEP;
            end
            state_d = RUN;
         end
         TRAP: begin
            flush_d = 1'b1;
            if (trap_ack) begin
               pc_d    = TRAP_VECTOR;
               trap_d  = 1'b0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      if (rst) begin
         taken_c     = 1'b0;
         fetch_valid = 1'b0;
         flush_d     = 1'b0;
         flush_e     = 1'b0;
      end
   end

`ifdef PC_PERF_CNT_EN
   // Branches seen in RUN, and accepted redirects including those that trap
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         if (state_q == RUN && branch_e) begin
            branch_cnt <= branch_cnt + 32'd1;
         end
         if (taken_c) begin
            taken_cnt <= taken_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed, table-driven bench for pc_redirect_unit (optionally with PC_PERF_CNT_EN).
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] pc_f;
   logic [31:0] pc_e;
   logic [31:0] imm_e;
   logic [31:0] rs1_e;
   logic        branch_e;
   logic        jump_e;
   logic        jalr_e;
   logic        br_out;
   logic        flush_d;
   logic        flush_e;
   logic        misalign_trap;
   logic [31:0] trap_tval;
   logic        trap_ack;
`ifdef PC_PERF_CNT_EN
   logic [31:0] branch_cnt;
   logic [31:0] taken_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_redirect_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .pc_f          (pc_f),
      .pc_e          (pc_e),
      .imm_e         (imm_e),
      .rs1_e         (rs1_e),
      .branch_e      (branch_e),
      .jump_e        (jump_e),
      .jalr_e        (jalr_e),
      .br_out        (br_out),
      .flush_d       (flush_d),
      .flush_e       (flush_e),
      .misalign_trap (misalign_trap),
      .trap_tval     (trap_tval),
      .trap_ack      (trap_ack)
`ifdef PC_PERF_CNT_EN
      ,
      .branch_cnt    (branch_cnt),
      .taken_cnt     (taken_cnt)
`endif
   );

   typedef struct {
      string       name;
      logic        stall;
      logic        ready;
      logic        br;
      logic        jmp;
      logic        jalr;
      logic        bo;
      logic        ack;
      logic [31:0] pc_e;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_fd;
      logic        e_fe;
      logic        e_trap;
      logic [31:0] e_tval;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   function automatic vec_t mk(string name, logic st, logic rdy, logic br, logic jmp,
                               logic jalr, logic bo, logic ack, logic [31:0] pe,
                               logic [31:0] im, logic [31:0] r1, logic [31:0] epc,
                               logic efv, logic efd, logic efe, logic etr, logic [31:0] etv);
      vec_t v;
      v.name = name; v.stall = st; v.ready = rdy; v.br = br; v.jmp = jmp; v.jalr = jalr;
      v.bo = bo; v.ack = ack; v.pc_e = pe; v.imm = im; v.rs1 = r1; v.e_pc = epc;
      v.e_fv = efv; v.e_fd = efd; v.e_fe = efe; v.e_trap = etr; v.e_tval = etv;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 1'b0; fetch_ready = 1'b1; branch_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0;
      br_out = 1'b0; trap_ack = 1'b0; pc_e = '0; imm_e = '0; rs1_e = '0;
   endtask

   // Outputs sampled 1 time unit after the falling edge, inputs already applied
   task automatic check_outputs(string tag, logic [31:0] epc, logic efv, logic efd,
                                logic efe, logic etr, logic [31:0] etv);
      chk({tag, ".pc_f"}, pc_f, epc);
      chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(efv));
      chk({tag, ".flush_d"}, 32'(flush_d), 32'(efd));
      chk({tag, ".flush_e"}, 32'(flush_e), 32'(efe));
      chk({tag, ".misalign_trap"}, 32'(misalign_trap), 32'(etr));
      chk({tag, ".trap_tval"}, trap_tval, etv);
   endtask

   initial begin
      //               name          st rdy br jmp jalr bo ack pc_e          imm       rs1        exp_pc        fv fd fe tr tval
      vecs[0]  = mk("boot",          0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h0,        0, 0, 0, 0, 32'h0);
      vecs[1]  = mk("run0",          0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h0,        1, 0, 0, 0, 32'h0);
      vecs[2]  = mk("run4",          0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h4,        1, 0, 0, 0, 32'h0);
      vecs[3]  = mk("not_ready",     0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h8,        1, 0, 0, 0, 32'h0);
      vecs[4]  = mk("stall",         1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h8,        1, 0, 0, 0, 32'h0);
      vecs[5]  = mk("run8",          0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h8,        1, 0, 0, 0, 32'h0);
      vecs[6]  = mk("br_taken",      0, 1, 1, 0, 0, 1, 0, 32'h10,       32'h20,   32'h0,    32'hC,        1, 1, 1, 0, 32'h0);
      vecs[7]  = mk("redir_30",      0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h30,       1, 0, 0, 0, 32'h0);
      vecs[8]  = mk("br_nt_stall",   1, 0, 1, 0, 0, 0, 0, 32'h10,       32'h20,   32'h0,    32'h34,       1, 0, 0, 0, 32'h0);
      vecs[9]  = mk("br_t_stall",    1, 0, 1, 0, 0, 1, 0, 32'h100,      32'h40,   32'h0,    32'h34,       1, 1, 1, 0, 32'h0);
      vecs[10] = mk("redir_stall",   1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h140,      1, 0, 0, 0, 32'h0);
      vecs[11] = mk("run140",        0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h140,      1, 0, 0, 0, 32'h0);
      vecs[12] = mk("jal_wrap",      0, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h20,  32'h0,    32'h144,      1, 1, 1, 0, 32'h0);
      vecs[13] = mk("redir_ignore",  0, 1, 1, 1, 0, 1, 0, 32'h200,      32'h0,    32'h0,    32'h10,       1, 0, 0, 0, 32'h0);
      vecs[14] = mk("run14",         0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h14,       1, 0, 0, 0, 32'h0);
      vecs[15] = mk("jalr_misal",    0, 1, 0, 1, 1, 0, 0, 32'h0,        32'h2,    32'h1001, 32'h18,       1, 1, 1, 0, 32'h0);
      vecs[16] = mk("trap_hold_j",   0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h40,   32'h0,    32'h18,       0, 1, 0, 1, 32'h1002);
      vecs[17] = mk("trap_hold",     0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h18,       0, 1, 0, 1, 32'h1002);
      vecs[18] = mk("trap_ack",      0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0,    32'h0,    32'h18,       0, 1, 0, 1, 32'h1002);
      vecs[19] = mk("trap_vec",      0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h100,      1, 0, 0, 0, 32'h1002);
      vecs[20] = mk("jalr_bit0",     0, 1, 0, 1, 1, 0, 0, 32'h0,        32'h5,    32'h2000, 32'h104,      1, 1, 1, 0, 32'h1002);
      vecs[21] = mk("redir_nrdy",    0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h2004,     1, 0, 0, 0, 32'h1002);
      vecs[22] = mk("run2004",       0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h2004,     1, 0, 0, 0, 32'h1002);
      vecs[23] = mk("br_misal",      0, 1, 1, 0, 0, 1, 0, 32'h40,       32'h6,    32'h0,    32'h2008,     1, 1, 1, 0, 32'h1002);
      vecs[24] = mk("trap2",         0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,    32'h2008,     0, 1, 0, 1, 32'h46);

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_outputs("reset", 32'h0, 0, 0, 0, 0, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (i > 0) @(negedge clk);
         stall = vecs[i].stall; fetch_ready = vecs[i].ready; branch_e = vecs[i].br;
         jump_e = vecs[i].jmp; jalr_e = vecs[i].jalr; br_out = vecs[i].bo;
         trap_ack = vecs[i].ack; pc_e = vecs[i].pc_e; imm_e = vecs[i].imm; rs1_e = vecs[i].rs1;
         #1;
         check_outputs(vecs[i].name, vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_fd,
                       vecs[i].e_fe, vecs[i].e_trap, vecs[i].e_tval);
      end

`ifdef PC_PERF_CNT_EN
      chk("branch_cnt", branch_cnt, 32'd4);
      chk("taken_cnt", taken_cnt, 32'd6);
`endif

      // Reset while parked in TRAP
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rst_in_trap.flush_d", 32'(flush_d), 32'h0);
      chk("rst_in_trap.fetch_valid", 32'(fetch_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs("after_rst_boot", 32'h0, 0, 0, 0, 0, 32'h0);
`ifdef PC_PERF_CNT_EN
      chk("branch_cnt_rst", branch_cnt, 32'd0);
      chk("taken_cnt_rst", taken_cnt, 32'd0);
`endif
      @(negedge clk);
      #1;
      check_outputs("after_rst_run0", 32'h0, 1, 0, 0, 0, 32'h0);
      @(negedge clk);
      #1;
      check_outputs("after_rst_run4", 32'h4, 1, 0, 0, 0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
